transition_scheduler: RTL

- Sequencer and arbiter in front of the 10-bit state-transition FSM.
- Collects 3-bit input codes from NUM_REQ requesters (e.g. front-panel buttons, test/replay source) through round-robin arbitration into a small FIFO.
- Issues one code at a time on the FSM's input wire, holds it stable, pulses a single step enable, then checks whether the 10-bit state changed.

---
 rtl/transition_pkg.sv | 13 +
 rtl/ts_rr_arbiter.sv | 37 +++
 rtl/transition_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/transition_pkg.sv
// Shared constants for the transition scheduler: code/state widths, idle code, FSM encodings.
package transition_pkg;
    localparam int CODE_W  = 3;
    localparam int STATE_W = 10;

    localparam logic [CODE_W-1:0] IDLE_CODE_DEFAULT = 3'b000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STEP    = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
endpackage

// File: rtl/ts_rr_arbiter.sv
// Round-robin grant across NUM_REQ requesters; combinational grant, pointer advances past the winner.
// Zero latency; grant_en low suppresses every grant so requesters hold.
module ts_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (grant_en && !found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = PTR_W'((idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/transition_scheduler.sv
// Arbitrates requester codes into a FIFO and sequences them onto the FSM input: hold, step, check.
// Pop-to-step STEP_CYCLES+1, pop-to-done STEP_CYCLES+2; req_ready drops while full, flushing or in reset.
// TRANSITION_SCHEDULER_IDLE_STEP_EN adds a RELEASE phase stepping the FSM once more with the idle code.
module transition_scheduler
    import transition_pkg::*;
#(
    parameter int                NUM_REQ     = 2,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                STEP_CYCLES = 4,
    parameter logic [CODE_W-1:0] IDLE_CODE   = IDLE_CODE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [CODE_W*NUM_REQ-1:0]     req_code,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush,
    input  logic [STATE_W-1:0]            state_in,
    output logic [CODE_W-1:0]             cmd_wire,
    output logic                          step_en,
    output logic                          busy,
    output logic                          done,
    output logic                          changed,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = $clog2(STEP_CYCLES + 1);

    logic [CODE_W-1:0]  mem_q [FIFO_DEPTH];
    logic [CODE_W-1:0]  mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [STATE_W-1:0] snap_q, snap_d;

    logic               fifo_full, fifo_empty, grant_en, push, pop;
    logic [CODE_W-1:0]  push_code;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign grant_en   = !reset && !flush && !fifo_full;
    assign push       = |(req_valid & req_ready);
    assign pop        = (state_q == ST_IDLE) && !fifo_empty && !flush;
    assign busy       = (state_q != ST_IDLE);
    assign fifo_count = count_q;

    ts_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .grant_en  (grant_en),
        .grant     (req_ready)
    );

    always_comb begin
        push_code = IDLE_CODE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) push_code = req_code[i*CODE_W +: CODE_W];
        end
    end

    // Flush wins over everything: arbitration and pop are both blocked while it is high.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_code;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) rd_d = rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        snap_d   = snap_q;
        cmd_wire = IDLE_CODE;
        step_en  = 1'b0;
        done     = 1'b0;
        changed  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    code_d  = mem_q[rd_q];
                    snap_d  = state_in;
                    cnt_d   = CNT_W'(STEP_CYCLES - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cmd_wire = code_q;
                if (cnt_q == '0) state_d = ST_STEP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_STEP: begin
                cmd_wire = code_q;
                step_en  = 1'b1;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                cmd_wire = code_q;
                done     = 1'b1;
                changed  = (state_in != snap_q);
`ifdef TRANSITION_SCHEDULER_IDLE_STEP_EN
                cnt_d    = CNT_W'(STEP_CYCLES);
                state_d  = ST_RELEASE;
`else
                state_d  = ST_IDLE;
`endif
            end
`ifdef TRANSITION_SCHEDULER_IDLE_STEP_EN
            // Idle code held STEP_CYCLES cycles, then the final count value pulses the release step.
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    step_en = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= IDLE_CODE;
            snap_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            snap_q  <= snap_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
